// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the multi-port register file.
package reg_file_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

endpackage

// File: rtl/reg_file_mp_if.sv
// Read/write/clear bus of the register file; master drives indices and writes.
interface reg_file_mp_if
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2
) ();

    logic [NUM_RD*ADDR_W-1:0] rd_idx;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     wr0_en;
    logic [ADDR_W-1:0]        wr0_idx;
    logic [DATA_W-1:0]        wr0_data;
    logic                     wr1_en;
    logic [ADDR_W-1:0]        wr1_idx;
    logic [DATA_W-1:0]        wr1_data;
    logic                     clr_req;
    logic                     ready;

    modport master (
        output rd_idx, wr0_en, wr0_idx, wr0_data, wr1_en, wr1_idx, wr1_data, clr_req,
        input  rd_data, ready
    );

    modport slave (
        input  rd_idx, wr0_en, wr0_idx, wr0_data, wr1_en, wr1_idx, wr1_data, clr_req,
        output rd_data, ready
    );

endinterface

// File: rtl/reg_clr_seq.sv
// CLEAR/READY controller: sweeps every entry to zero after reset or clr_req.
module reg_clr_seq
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req_i,
    output logic              clr_en_o,
    output logic [ADDR_W-1:0] clr_idx_o,
    output logic              ready_o
);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   clr_idx_q, clr_idx_d;
    logic [ADDR_W:0]   clr_idx_inc;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // NOTE: defaults first so no path through this block can infer a latch.
    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        clr_idx_inc = clr_idx_q + {{ADDR_W{1'b0}}, 1'b1};
        unique case (state_q)
            ST_CLEAR: begin
                clr_idx_d = clr_idx_inc;
                // Carry into the extra bit means entry DEPTH-1 was just zeroed.
                if (clr_idx_inc[ADDR_W]) begin
                    state_d   = ST_READY;
                    clr_idx_d = '0;
                end
            end
            ST_READY: begin
                if (clr_req_i) begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = '0;
                end
            end
        endcase
    end

    assign clr_en_o  = (state_q == ST_CLEAR);
    assign clr_idx_o = clr_idx_q[ADDR_W-1:0];
    assign ready_o   = (state_q == ST_READY);

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: two write ports, NUM_RD combinational read ports
// with write-first bypass, and a one-entry-per-cycle clear sweep.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input logic          clk,
    input logic          rst,
    reg_file_mp_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0]        mem_q [DEPTH];
    logic                     clr_en;
    logic [ADDR_W-1:0]        clr_idx;
    logic                     ready;
    logic                     wr0_ok, wr1_ok;
    logic [NUM_RD*DATA_W-1:0] rd_data;

    reg_clr_seq #(.ADDR_W(ADDR_W)) u_clr_seq (
        .clk       (clk),
        .rst       (rst),
        .clr_req_i (bus.clr_req),
        .clr_en_o  (clr_en),
        .clr_idx_o (clr_idx),
        .ready_o   (ready)
    );

    // Index-0 writes are dropped here so neither storage nor bypass ever sees them.
    assign wr0_ok = ready && !rst && bus.wr0_en && !((ZERO_REG != 0) && (bus.wr0_idx == '0));
    assign wr1_ok = ready && !rst && bus.wr1_en && !((ZERO_REG != 0) && (bus.wr1_idx == '0));

    // NOTE: the array has no reset branch; it is zeroed by the clear sweep instead.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem_q[clr_idx] <= '0;
        end else begin
            if (wr0_ok) mem_q[bus.wr0_idx] <= bus.wr0_data;
            if (wr1_ok) mem_q[bus.wr1_idx] <= bus.wr1_data;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] idx;
        logic              zero_hit, hit0, hit1;

        assign idx      = bus.rd_idx[k*ADDR_W +: ADDR_W];
        assign zero_hit = (ZERO_REG != 0) && (idx == '0);
        assign hit0     = wr0_ok && (bus.wr0_idx == idx);
        assign hit1     = wr1_ok && (bus.wr1_idx == idx);

        assign rd_data[k*DATA_W +: DATA_W] = (!ready || zero_hit) ? '0 :
                                             hit1                 ? bus.wr1_data :
                                             hit0                 ? bus.wr0_data :
                                                                    mem_q[idx];
    end

    assign bus.rd_data = rd_data;
    assign bus.ready   = ready;

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: directed scenarios followed by random traffic,
// checked against an array-based reference model.
module tb_reg_file_mp;
    import reg_file_pkg::*;

    localparam int DATA_W = DEF_DATA_W;
    localparam int ADDR_W = DEF_ADDR_W;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_file_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

    reg_file_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic                     ready;
        logic [NUM_RD*DATA_W-1:0] data;
        int                       cyc;
    } exp_t;

    exp_t              sb_q[$];
    logic [DATA_W-1:0] m_mem [DEPTH];
    int                m_clear_left;
    int                cyc;
    int                n_vec  = 0;
    int                n_miss = 0;

    task automatic check(input string name, input int at, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, at, act, exp);
        end
    endtask

    // Reference model: a clear empties the whole file at once and then blocks
    // everything for DEPTH cycles.
    function automatic logic [DATA_W-1:0] model_read(input int idx);
        if (m_clear_left > 0 || idx == 0) return '0;
        if (!rst && bus.wr1_en && int'(bus.wr1_idx) == idx) return bus.wr1_data;
        if (!rst && bus.wr0_en && int'(bus.wr0_idx) == idx) return bus.wr0_data;
        return m_mem[idx];
    endfunction

    task automatic model_zero();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_clear_left = DEPTH;
    endtask

    task automatic model_commit();
        if (rst) begin
            model_zero();
        end else if (m_clear_left > 0) begin
            m_clear_left--;
        end else begin
            if (bus.wr0_en && bus.wr0_idx != '0) m_mem[bus.wr0_idx] = bus.wr0_data;
            if (bus.wr1_en && bus.wr1_idx != '0) m_mem[bus.wr1_idx] = bus.wr1_data;
            if (bus.clr_req) model_zero();
        end
    endtask

    // Push the expected response for the inputs currently driven, then clock.
    task automatic step();
        exp_t e;
        e.ready = (m_clear_left == 0);
        for (int k = 0; k < NUM_RD; k++)
            e.data[k*DATA_W +: DATA_W] = model_read(int'(bus.rd_idx[k*ADDR_W +: ADDR_W]));
        e.cyc = cyc;
        sb_q.push_back(e);
        @(posedge clk);
        model_commit();
        cyc++;
        #1;
    endtask

    task automatic set_rd_all(input int idx);
        for (int k = 0; k < NUM_RD; k++) bus.rd_idx[k*ADDR_W +: ADDR_W] = ADDR_W'(idx);
    endtask

    task automatic idle();
        rst         = 1'b0;
        bus.wr0_en  = 1'b0;
        bus.wr1_en  = 1'b0;
        bus.clr_req = 1'b0;
        for (int k = 0; k < NUM_RD; k++)
            bus.rd_idx[k*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, DEPTH - 1));
    endtask

    task automatic rand_inputs(input int clr_pct, input int rst_pct);
        bus.wr0_en   = 1'($urandom_range(0, 1));
        bus.wr0_idx  = ADDR_W'($urandom_range(0, DEPTH - 1));
        bus.wr0_data = $urandom;
        bus.wr1_en   = 1'($urandom_range(0, 1));
        bus.wr1_idx  = ($urandom_range(0, 3) == 0) ? bus.wr0_idx
                                                    : ADDR_W'($urandom_range(0, DEPTH - 1));
        bus.wr1_data = $urandom;
        for (int k = 0; k < NUM_RD; k++) begin
            case ($urandom_range(0, 3))
                0:       bus.rd_idx[k*ADDR_W +: ADDR_W] = bus.wr0_idx;
                1:       bus.rd_idx[k*ADDR_W +: ADDR_W] = bus.wr1_idx;
                default: bus.rd_idx[k*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, DEPTH - 1));
            endcase
        end
        bus.clr_req = ($urandom_range(0, 99) < clr_pct);
        rst         = ($urandom_range(0, 99) < rst_pct);
    endtask

    // Runs random traffic (writes and clr_req included) until ready rises.
    task automatic count_clear(input string name);
        int n = 0;
        while (!bus.ready && n < 40) begin
            rand_inputs(20, 0);
            step();
            n++;
        end
        check(name, cyc, DATA_W'(n), DATA_W'(DEPTH));
        idle();
    endtask

    task automatic read_all();
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            for (int k = 0; k < NUM_RD; k++)
                bus.rd_idx[k*ADDR_W +: ADDR_W] = ADDR_W'((i + k) % DEPTH);
            step();
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("ready", e.cyc, DATA_W'(bus.ready), DATA_W'(e.ready));
                for (int k = 0; k < NUM_RD; k++)
                    check($sformatf("rd%0d", k), e.cyc, bus.rd_data[k*DATA_W +: DATA_W],
                          e.data[k*DATA_W +: DATA_W]);
            end
        end
    end

    initial begin : stimulus
        cyc = 0;
        bus.wr0_en = 1'b0; bus.wr0_idx = '0; bus.wr0_data = '0;
        bus.wr1_en = 1'b0; bus.wr1_idx = '0; bus.wr1_data = '0;
        bus.clr_req = 1'b0; bus.rd_idx = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_zero();

        // Reset held, then the power-up sweep and an all-zero readback.
        for (int i = 0; i < 3; i++) begin
            idle();
            rst = 1'b1;
            step();
        end
        idle();
        count_clear("clear_len_reset");
        read_all();

        // Port 0 write with same-cycle bypass, then stored value.
        idle();
        bus.wr0_en = 1'b1; bus.wr0_idx = ADDR_W'(7); bus.wr0_data = 32'hDEADBEEF;
        set_rd_all(7);
        step();
        idle(); set_rd_all(7); step();

        // Same-index conflict: port 1 wins.
        idle();
        bus.wr0_en = 1'b1; bus.wr0_idx = ADDR_W'(3); bus.wr0_data = 32'h11111111;
        bus.wr1_en = 1'b1; bus.wr1_idx = ADDR_W'(3); bus.wr1_data = 32'h22222222;
        set_rd_all(3);
        step();
        idle(); set_rd_all(3); step();

        // Index 0 is hard-wired to zero.
        idle();
        bus.wr0_en = 1'b1; bus.wr0_idx = '0; bus.wr0_data = 32'h5A5A5A5A;
        bus.wr1_en = 1'b1; bus.wr1_idx = '0; bus.wr1_data = 32'h5A5A5A5A;
        set_rd_all(0);
        step();
        idle(); set_rd_all(0); step();

        // Fill, clear request, writes ignored during the sweep.
        for (int i = 1; i < DEPTH; i++) begin
            idle();
            bus.wr0_en = 1'b1; bus.wr0_idx = ADDR_W'(i); bus.wr0_data = DATA_W'(i);
            step();
        end
        read_all();
        idle(); bus.clr_req = 1'b1; step();
        idle();
        count_clear("clear_len_req");
        read_all();

        // Reset at clr_idx=20 restarts the sweep.
        for (int i = 1; i < DEPTH; i++) begin
            idle();
            bus.wr1_en = 1'b1; bus.wr1_idx = ADDR_W'(i); bus.wr1_data = $urandom;
            step();
        end
        idle(); bus.clr_req = 1'b1; step();
        for (int i = 0; i < 20; i++) begin idle(); step(); end
        idle(); rst = 1'b1; step();
        idle();
        count_clear("clear_len_rst");
        read_all();

        // Random traffic with occasional clears and resets.
        for (int i = 0; i < 800; i++) begin
            rand_inputs(2, 1);
            step();
        end
        idle();
        step();

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 5, index width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter NUM_RD, default 2, number of read ports, range 1..4.
REQ-004 Parameter ZERO_REG, default 1; when 1, entry 0 is hard-wired to zero.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 rd_idx  in  NUM_RD*ADDR_W  read indices; port k occupies bits [k*ADDR_W +: ADDR_W].
REQ-008 rd_data  out  NUM_RD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W].
REQ-009 wr0_en  in  1  write port 0 enable.
REQ-010 wr0_idx  in  ADDR_W  write port 0 index.
REQ-011 wr0_data  in  DATA_W  write port 0 data.
REQ-012 wr1_en / wr1_idx / wr1_data  in  1 / ADDR_W / DATA_W  write port 1, same meaning as port 0.
REQ-013 clr_req  in  1  single-cycle request to zero the whole file.
REQ-014 ready  out  1  high when the file accepts writes and returns stored data.

Function
REQ-015 Controller states: CLEAR and READY only.
REQ-016 CLEAR: a counter clr_idx steps 0..DEPTH-1, one entry zeroed per cycle; after entry DEPTH-1 is zeroed, the next state is READY.
REQ-017 CLEAR lasts exactly DEPTH cycles; ready rises on the first cycle after the last entry is zeroed.
REQ-018 In CLEAR: wr0_en and wr1_en are ignored, all rd_data ports drive 0, and clr_req is ignored.
REQ-019 In READY: clr_req=1 moves to CLEAR with clr_idx=0 on the next cycle; any write presented in that same cycle is performed first.
REQ-020 Writes are combined per cycle: with wrN_en=1, entry wrN_idx takes wrN_data at the clock edge.
REQ-021 Same-index conflict: when wr0_en=wr1_en=1 and wr0_idx==wr1_idx, port 1's data is stored.
REQ-022 With ZERO_REG=1: writes to index 0 are dropped, and reads of index 0 return 0 in every state.
REQ-023 Reads are combinational from rd_idx with write-first bypass: if in READY a write to the read index is enabled in the same cycle, rd_data returns that write data, port 1 taking priority; dropped index-0 writes are never bypassed.
REQ-024 Read ports are independent; any number of ports may read the same index.
REQ-025 No arithmetic on data; clr_idx is ADDR_W+1 bits wide, so its wrap at DEPTH terminates CLEAR without overflow.

Reset
REQ-026 rst=1 at a clock edge sets state=CLEAR, clr_idx=0, ready=0; all rd_data ports read 0 from that edge onward.
REQ-027 The storage array has no direct reset; it is zeroed by the CLEAR sweep.
REQ-028 rst asserted mid-CLEAR restarts the sweep at clr_idx=0; rst held for N cycles delays READY by N cycles.
REQ-029 rst has priority over clr_req and all writes.

Structure
REQ-030 Shared package reg_file_pkg holds the state enumeration (CLEAR, READY) and the default DATA_W / ADDR_W constants.
REQ-031 One sub-module, reg_clr_seq, holds the state register, clr_idx counter, and ready generation; the storage array, write muxing and read bypass stay in reg_file_mp.
REQ-032 The storage array is a single clocked process; the read/bypass path has no registers.

Verification
REQ-033 Release rst, ADDR_W=5 -> ready low for exactly 32 cycles, then high; every index reads 0.
REQ-034 READY: write 0xDEADBEEF to index 7 via port 0 -> same-cycle read of index 7 returns 0xDEADBEEF (bypass), and it still does on the next cycle.
REQ-035 Both ports write index 3 (port 0 0x11111111, port 1 0x22222222) -> index 3 reads 0x22222222 in that cycle and the next.
REQ-036 ZERO_REG=1: write 0x5A5A5A5A to index 0 -> all ports read 0 for index 0, including the same-cycle read.
REQ-037 Fill indices 1..31 with their index value, pulse clr_req -> ready low for 32 cycles, writes during that window are ignored, and all entries read 0 afterwards.
REQ-038 Assert rst at clr_idx=20 for 1 cycle -> sweep restarts and ready rises 32 cycles after rst drops.
